dpwm_duty_scheduler: RTL
========================

Name: dpwm_duty_scheduler

Overview:
- Sequences the 9-bit duty word fed to the dithered DPWM, which consumes a 6-bit MSB duty plus a 3-bit dither LSB over an 8-period dither frame.
- Accepts duty commands from the compensator over a valid/ready handshake.
- Applies new commands only on dither-frame boundaries, so a frame's dither pattern is never split.
- Provides soft-start ramping, DMAX clamping and fault shutdown.

Parameters:
DW, 9, duty word width; matches the DPWM duty input.
DMAX, 460, maximum duty code; every applied value is clamped to this.
SS_STEP, 4, soft-start increment per dither frame, in LSB units.
SLEW_MAX, 16, maximum per-frame duty change in RUN (used only with the optional feature).

Ports:
clk_in  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
en  input  1  converter enable, level.
fault  input  1  fault level (OCP/OVP); highest priority.
pwm_tick  input  1  one-cycle strobe at the start of each switching period.
cmd_valid  input  1  compensator duty command valid.
cmd_duty  input  DW  compensator duty command.
cmd_ready  output  1  scheduler can accept a command.
d_n_out  output  DW  duty word to the DPWM; registered.
frame_pos  output  3  period index within the dither frame (0..7).
frame_start  output  1  registered one-cycle pulse; first period of a new frame.
ss_done  output  1  soft-start complete; high in RUN.
state  output  2  IDLE=00, SOFT=01, RUN=10, FAULT=11.

Behaviour:
- Reset: state=IDLE. d_n_out, frame_pos, frame_start, ss_done, target and pending_valid all reset to 0.
- Accept event: acc = cmd_valid & cmd_ready. On acc, the captured value is min(cmd_duty, DMAX).
- Frame boundary: fb = pwm_tick & (frame_pos==7) & (state is SOFT or RUN).
- frame_pos counting:
  - In SOFT/RUN, increments on each pwm_tick and wraps 7->0.
  - Forced to 0 in IDLE/FAULT.
  - frame_start is asserted for one cycle in the cycle after fb.
- IDLE:
  - d_n_out=0; cmd_ready=1; acc loads target.
  - en=1 & fault=0 -> SOFT on the next edge.
- SOFT:
  - cmd_ready=1; acc updates target.
  - At fb: d_n_out <= min(d_n_out+SS_STEP, target), computed at DW+1 bits to avoid wrap.
  - If the new value equals target -> RUN and ss_done=1, effective from that same edge.
  - If target < d_n_out at fb (target lowered mid-ramp): d_n_out <= target, -> RUN.
  - target=0 at entry: the first fb gives d_n_out=0 -> RUN.
- RUN:
  - One-deep pending buffer; cmd_ready = ~pending_valid (combinational).
  - acc loads pending and sets pending_valid.
  - At fb with pending_valid: d_n_out <= pending and pending_valid clears.
  - At fb without pending: d_n_out holds.
  - A command accepted in the fb cycle itself (only possible when the buffer was empty) waits for the next fb.
  - Latency from acc to d_n_out change: 1..8 periods, then 1 clk_in.
- en falls in SOFT/RUN:
  - -> IDLE on the next edge.
  - d_n_out=0, pending_valid=0, ss_done=0.
  - target is retained.
- fault=1 in any state:
  - -> FAULT on the next edge.
  - d_n_out=0, cmd_ready=0, pending cleared, ss_done=0.
- Leaving FAULT: only when fault=0 & en=0 -> IDLE. There is no auto-restart.
- Priority: rst > fault > en low > fb/acc.
- Reset mid-operation: asynchronous clear to the reset values above within the same cycle.

Optional Feature:
DPWM_SLEW_LIMIT_EN
- Defined: in RUN at fb, the applied value is pending clamped to d_n_out ± SLEW_MAX.
  - If the clamp bound, pending_valid stays set and pending is kept.
  - Each following fb advances by up to SLEW_MAX until pending is reached.
  - cmd_ready stays 0 until pending is reached.
  - A new command therefore waits until the current one has been fully applied.
- Undefined: the pending value is applied in full at the next fb.

Test Plan:
- Reset: assert rst mid-RUN at d_n_out=200 -> all outputs 0 and state=00 immediately; after release, state stays 00 with en=0.
- Soft-start: target=10, en=1, pwm_tick every 4 clocks -> d_n_out steps 4, 8, 10 at successive fb; state 01->10 and ss_done=1 on the 10 step; each step exactly 32 clocks apart.
- RUN update:
  - cmd 300 accepted at frame_pos=2 -> d_n_out=300 one clk_in after the next fb; cmd_ready low until that fb.
  - A second cmd accepted in that fb cycle applies at the following fb.
- Clamp: cmd_duty=511 -> d_n_out=460; soft-start with target=459, SS_STEP=4 -> last step 456->459 with no overshoot.
- Fault: fault pulse during SOFT -> state=11, d_n_out=0; fault=0 with en=1 stays 11; en=0 -> 00.
- Slew (macro defined): RUN at 100, cmd 150 -> d_n_out 116, 132, 148, 150 on successive fb; cmd_ready returns high only after 150 is applied.

Source files
------------

// File: rtl/dpwm_duty_scheduler.sv
// dpwm_duty_scheduler: sequences the 9-bit duty word for a dithered DPWM.
// Duty changes land only on dither-frame boundaries (every 8th pwm_tick).
// The scheduler also does soft-start ramping, DMAX clamping and fault
// shutdown.
// Optional feature macro: DPWM_SLEW_LIMIT_EN. When it is defined, each
// frame-boundary step in RUN is limited to +/- SLEW_MAX.
module dpwm_duty_scheduler #(
  parameter int DW       = 9,
  parameter int DMAX     = 460,
  parameter int SS_STEP  = 4,
  parameter int SLEW_MAX = 16
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          en,
  input  logic          fault,
  input  logic          pwm_tick,
  input  logic          cmd_valid,
  input  logic [DW-1:0] cmd_duty,
  output logic          cmd_ready,
  output logic [DW-1:0] d_n_out,
  output logic [2:0]    frame_pos,
  output logic          frame_start,
  output logic          ss_done,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SOFT  = 2'b01,
    RUN   = 2'b10,
    FAULT = 2'b11
  } state_e;

  // One extra bit, so that ramp/slew sums cannot wrap.
  localparam int WW = DW + 1;
  localparam logic [DW-1:0] DMAX_C  = DW'(DMAX);
  localparam logic [WW-1:0] SS_W    = WW'(SS_STEP);
  localparam logic [WW-1:0] SLEW_W  = WW'(SLEW_MAX);

  state_e        state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [2:0]    pos_q, pos_d;
  logic          fstart_q, fstart_d;
  logic          ss_done_q, ss_done_d;
  logic [DW-1:0] target_q, target_d;
  logic [DW-1:0] pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;

  logic          active;
  logic          fb;
  logic          acc;
  logic [DW-1:0] cmd_clamped;
  logic [WW-1:0] ss_sum;

  assign active      = (state_q == SOFT) || (state_q == RUN);
  assign fb          = pwm_tick && (pos_q == 3'd7) && active;
  assign acc         = cmd_valid && cmd_ready;
  assign cmd_clamped = (cmd_duty > DMAX_C) ? DMAX_C : cmd_duty;
  assign ss_sum      = {1'b0, duty_q} + SS_W;

  // The ready signal depends only on state and buffer occupancy, so it does
  // not combinationally depend on cmd_valid.
  always_comb begin
    unique case (state_q)
      IDLE, SOFT: cmd_ready = 1'b1;
      RUN:        cmd_ready = ~pend_valid_q;
      default:    cmd_ready = 1'b0;
    endcase
  end

  // Next-state and datapath update; the exits to FAULT and IDLE override everything else.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d      = state_q;
    duty_d       = duty_q;
    pos_d        = pos_q;
    fstart_d     = fb;
    ss_done_d    = ss_done_q;
    target_d     = target_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    if (active && pwm_tick) pos_d = pos_q + 3'd1;

    unique case (state_q)
      IDLE: begin
        duty_d = '0;
        pos_d  = '0;
        if (acc) target_d = cmd_clamped;
        if (en) state_d = SOFT;
      end
      SOFT: begin
        if (acc) target_d = cmd_clamped;
        if (fb) begin
          if ((target_q < duty_q) || (ss_sum >= {1'b0, target_q})) begin
            duty_d    = target_q;
            state_d   = RUN;
            ss_done_d = 1'b1;
          end else begin
            duty_d = ss_sum[DW-1:0];
          end
        end
      end
      RUN: begin
        if (acc) begin
          pend_d       = cmd_clamped;
          pend_valid_d = 1'b1;
        end
        if (fb && pend_valid_q) begin
`ifdef DPWM_SLEW_LIMIT_EN
          if ({1'b0, pend_q} > ({1'b0, duty_q} + SLEW_W)) begin
            duty_d = duty_q + SLEW_W[DW-1:0];
          end else if (({1'b0, pend_q} + SLEW_W) < {1'b0, duty_q}) begin
            duty_d = duty_q - SLEW_W[DW-1:0];
          end else begin
            duty_d       = pend_q;
            pend_valid_d = 1'b0;
          end
`else
          duty_d       = pend_q;
          pend_valid_d = 1'b0;
`endif
        end
      end
      default: begin
        duty_d       = '0;
        pos_d        = '0;
        pend_valid_d = 1'b0;
        ss_done_d    = 1'b0;
        if (!fault && !en) state_d = IDLE;
      end
    endcase

    if (fault && (state_q != FAULT)) begin
      state_d      = FAULT;
      duty_d       = '0;
      pos_d        = '0;
      fstart_d     = 1'b0;
      ss_done_d    = 1'b0;
      pend_valid_d = 1'b0;
    end else if (active && !en) begin
      state_d      = IDLE;
      duty_d       = '0;
      pos_d        = '0;
      fstart_d     = 1'b0;
      ss_done_d    = 1'b0;
      pend_valid_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-high clear.
  always_ff @(posedge clk_in or posedge rst) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      duty_q       <= '0;
      pos_q        <= '0;
      fstart_q     <= 1'b0;
      ss_done_q    <= 1'b0;
      target_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      pos_q        <= pos_d;
      fstart_q     <= fstart_d;
      ss_done_q    <= ss_done_d;
      target_q     <= target_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign d_n_out     = duty_q;
  assign frame_pos   = pos_q;
  assign frame_start = fstart_q;
  assign ss_done     = ss_done_q;
  assign state       = state_q;

endmodule
